hazard_stall_ctrl: RTL

- Produces the `stall` and bubble controls consumed by the IF/ID and ID/EXE pipeline registers.
- Keeps a shadow scoreboard of in-flight register writes for the stages between ID and register-file write.
- Compares the decoding instruction's sources against the scoreboard and holds ID until every conflicting writer has retired.
- Exports saturating stall-cycle and stall-episode counters for CPI measurement.

---
 rtl/hazard_stall_ctrl_if.sv | 24 ++
 rtl/hazard_stall_ctrl.sv | 71 +++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage hazard signals exchanged between the decode stage and the stall controller.
interface hazard_stall_ctrl_if;
  logic [31:0] ID_Inst;
  logic        ID_Valid;
  logic        ID_UsesRs;
  logic        ID_UsesRt;
  logic        ID_RegWr;
  logic [4:0]  ID_Rw;
  logic        Freeze;
  logic        stall;
  logic        bubble;
  logic [15:0] StallCycles;
  logic [15:0] StallEvents;

  modport master (
    output ID_Inst, ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWr, ID_Rw, Freeze,
    input  stall, bubble, StallCycles, StallEvents
  );

  modport slave (
    input  ID_Inst, ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWr, ID_Rw, Freeze,
    output stall, bubble, StallCycles, StallEvents
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / RAW stall controller: shadow scoreboard of in-flight writes after ID,
// combinational stall/bubble, and saturating stall-cycle / stall-episode counters.
module hazard_stall_ctrl #(
  parameter int unsigned DEPTH = 2
) (
  input logic                 CLK,
  input logic                 reset,
  hazard_stall_ctrl_if.slave  bus
);

  logic [DEPTH-1:0]      sb_wr;
  logic [DEPTH-1:0][4:0] sb_rw;
  logic                  prev_hit;
  logic [15:0]           stall_cycles;
  logic [15:0]           stall_events;

  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_match;
  logic       rt_match;
  logic       hit;
  logic       newwr;
  logic       unused_inst_bits;

  assign rs    = bus.ID_Inst[25:21];
  assign rt    = bus.ID_Inst[20:16];
  assign newwr = bus.ID_Valid & bus.ID_RegWr & (bus.ID_Rw != 5'd0);
  assign unused_inst_bits = ^{bus.ID_Inst[31:26], bus.ID_Inst[15:0]};

  always_comb begin
    rs_match = 1'b0;
    rt_match = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (sb_wr[k] && (sb_rw[k] == rs)) rs_match = 1'b1;
      if (sb_wr[k] && (sb_rw[k] == rt)) rt_match = 1'b1;
    end
    hit = bus.ID_Valid &
          ((bus.ID_UsesRs & (rs != 5'd0) & rs_match) |
           (bus.ID_UsesRt & (rt != 5'd0) & rt_match));
  end

  // Gated by reset so the pipeline registers see no hold while the controller is cleared.
  assign bus.stall       = ~reset & (bus.Freeze | hit);
  assign bus.bubble      = ~reset & hit & ~bus.Freeze;
  assign bus.StallCycles = stall_cycles;
  assign bus.StallEvents = stall_events;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sb_wr        <= '0;
      sb_rw        <= '0;
      prev_hit     <= 1'b0;
      stall_cycles <= '0;
      stall_events <= '0;
    end else if (!bus.Freeze) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sb_wr[k] <= sb_wr[k-1];
        sb_rw[k] <= sb_rw[k-1];
      end
      // A stalled instruction stays in ID, so a bubble enters EXE instead of its write.
      sb_wr[0] <= hit ? 1'b0 : newwr;
      sb_rw[0] <= hit ? 5'd0 : bus.ID_Rw;
      prev_hit <= hit;
      if (hit) begin
        if (stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
        if (!prev_hit && (stall_events != 16'hFFFF)) stall_events <= stall_events + 16'd1;
      end
    end
  end

endmodule
